// File: rtl/peripheral_ctrl_pkg.sv
// Shared constants for the 0x4xxx_xxxx peripheral region: region tag, register offsets, TCON bits.
// Also used by the MEM-stage address decode and by data memory.
package peripheral_ctrl_pkg;

   localparam logic [3:0]  REGION_TAG = 4'h4;

   localparam logic [27:0] OFF_TH   = 28'h000_0000;
   localparam logic [27:0] OFF_TL   = 28'h000_0004;
   localparam logic [27:0] OFF_TCON = 28'h000_0008;
   localparam logic [27:0] OFF_LED  = 28'h000_000C;
   localparam logic [27:0] OFF_SW   = 28'h000_0010;
   localparam logic [27:0] OFF_DIGI = 28'h000_0014;
   localparam logic [27:0] OFF_TICK = 28'h000_0018;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_IS = 2;

   localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      SEL_TH, SEL_TL, SEL_TCON, SEL_LED, SEL_SW, SEL_DIGI, SEL_TICK, SEL_NONE
   } reg_sel_e;

   function automatic reg_sel_e decode_addr(input logic [31:0] addr);
      reg_sel_e sel;
      sel = SEL_NONE;
      if (addr[31:28] == REGION_TAG) begin
         case (addr[27:0])
            OFF_TH:   sel = SEL_TH;
            OFF_TL:   sel = SEL_TL;
            OFF_TCON: sel = SEL_TCON;
            OFF_LED:  sel = SEL_LED;
            OFF_SW:   sel = SEL_SW;
            OFF_DIGI: sel = SEL_DIGI;
            OFF_TICK: sel = SEL_TICK;
            default:  sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/peripheral_ctrl_timer.sv
// Reloadable interrupt timer: TH/TL/TCON plus overflow and CPU-write priority.
module periph_timer
   import peripheral_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_th,
   input  logic        we_tl,
   input  logic        we_tcon,
   input  logic [31:0] wdata_i,
   output logic [31:0] th_o,
   output logic [31:0] tl_o,
   output logic [2:0]  tcon_o,
   output logic        irq_pend_o
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic        ovf;

   assign ovf = tcon_q[TCON_EN] && (tl_q == TL_MAX);

   always_comb begin
      th_d = we_th ? wdata_i : th_q;

      // A CPU write to TL beats both increment and reload in the same cycle.
      tl_d = tl_q;
      if (we_tl)
         tl_d = wdata_i;
      else if (tcon_q[TCON_EN])
         tl_d = ovf ? th_q : tl_q + 32'd1;

      // An overflow in the same cycle as a TCON write still sets status.
      tcon_d = tcon_q;
      if (we_tcon)
         tcon_d = wdata_i[2:0];
      if (ovf && tcon_q[TCON_IE])
         tcon_d[TCON_IS] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         th_q   <= '0;
         tl_q   <= '0;
         tcon_q <= '0;
      end else begin
         th_q   <= th_d;
         tl_q   <= tl_d;
         tcon_q <= tcon_d;
      end
   end

   assign th_o       = th_q;
   assign tl_o       = tl_q;
   assign tcon_o     = tcon_q;
   assign irq_pend_o = tcon_q[TCON_IS] & tcon_q[TCON_IE];

endmodule

// File: rtl/peripheral_ctrl.sv
// Memory-mapped peripheral block: decode, LED/7-seg/tick registers, switch sync, read mux, irq gating.
module peripheral_ctrl
   import peripheral_ctrl_pkg::*;
#(
   parameter int SW_W   = 8,
   parameter int LED_W  = 8,
   parameter int DIGI_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cre_i,
   input  logic              cwe_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              pc31_i,
   input  logic [SW_W-1:0]   switch_i,
   output logic [31:0]       rdata_o,
   output logic              intreq_o,
   output logic [LED_W-1:0]  led_o,
   output logic [DIGI_W-1:0] digi_o
);

   reg_sel_e          sel;
   logic [31:0]       th, tl;
   logic [2:0]        tcon;
   logic              irq_pend;

   logic [LED_W-1:0]  led_q, led_d;
   logic [DIGI_W-1:0] digi_q, digi_d;
   logic [31:0]       tick_q, tick_d;
   logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
   logic [SW_W-1:0]   sw_sync_q, sw_sync_d;

   assign sel = decode_addr(addr_i);

   periph_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .we_th      (cwe_i && (sel == SEL_TH)),
      .we_tl      (cwe_i && (sel == SEL_TL)),
      .we_tcon    (cwe_i && (sel == SEL_TCON)),
      .wdata_i    (wdata_i),
      .th_o       (th),
      .tl_o       (tl),
      .tcon_o     (tcon),
      .irq_pend_o (irq_pend)
   );

   always_comb begin
      led_d = led_q;
      if (cwe_i && (sel == SEL_LED))
         led_d = wdata_i[LED_W-1:0];
      digi_d = digi_q;
      if (cwe_i && (sel == SEL_DIGI))
         digi_d = wdata_i[DIGI_W-1:0];
      tick_d    = tick_q + 32'd1;
      sw_meta_d = switch_i;
      sw_sync_d = sw_meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q     <= '0;
         digi_q    <= '0;
         tick_q    <= '0;
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         led_q     <= led_d;
         digi_q    <= digi_d;
         tick_q    <= tick_d;
         sw_meta_q <= sw_meta_d;
         sw_sync_q <= sw_sync_d;
      end
   end

   // Reads see pre-edge register state, so read+write in one cycle returns the old value.
   always_comb begin
      rdata_o = '0;
      if (cre_i) begin
         case (sel)
            SEL_TH:   rdata_o = th;
            SEL_TL:   rdata_o = tl;
            SEL_TCON: rdata_o = {29'd0, tcon};
            SEL_LED:  rdata_o = 32'(led_q);
            SEL_SW:   rdata_o = 32'(sw_sync_q);
            SEL_DIGI: rdata_o = 32'(digi_q);
            SEL_TICK: rdata_o = tick_q;
            default:  rdata_o = '0;
         endcase
      end
   end

   assign intreq_o = irq_pend & ~pc31_i;
   assign led_o    = led_q;
   assign digi_o   = digi_q;

endmodule
